// File: rtl/wired_bpu_upd_sched_if.sv
// Correction-port bundle between the backend/commit stage and the branch predictor update scheduler.
interface wired_bpu_upd_sched_if;
    logic        r_valid_i;
    logic [31:0] r_target_i;
    logic        r_tid_i;

    logic        u_valid_i;
    logic        u_ready_o;
    logic [31:0] u_pc_i;
    logic [31:0] u_target_i;
    logic [1:0]  u_type_i;
    logic        u_cond_i;
    logic        u_taken_i;
    logic [4:0]  u_history_i;
    logic [1:0]  u_lphr_i;
    logic [2:0]  u_ras_ptr_i;
    logic        u_miss_i;

    logic        c_redirect_o;
    logic [31:0] c_true_target_o;
    logic        c_tid_o;
    logic        c_need_update_o;
    logic        c_miss_o;
    logic [31:0] c_pc_o;
    logic [31:0] c_btb_target_o;
    logic [1:0]  c_type_o;
    logic        c_cond_o;
    logic        c_taken_o;
    logic [4:0]  c_history_o;
    logic [1:0]  c_lphr_o;
    logic [2:0]  c_ras_ptr_o;
    logic        busy_o;

    modport master (
        output r_valid_i, r_target_i, r_tid_i,
        output u_valid_i, u_pc_i, u_target_i, u_type_i, u_cond_i, u_taken_i,
        output u_history_i, u_lphr_i, u_ras_ptr_i, u_miss_i,
        input  u_ready_o,
        input  c_redirect_o, c_true_target_o, c_tid_o, c_need_update_o, c_miss_o,
        input  c_pc_o, c_btb_target_o, c_type_o, c_cond_o, c_taken_o,
        input  c_history_o, c_lphr_o, c_ras_ptr_o, busy_o
    );

    modport slave (
        input  r_valid_i, r_target_i, r_tid_i,
        input  u_valid_i, u_pc_i, u_target_i, u_type_i, u_cond_i, u_taken_i,
        input  u_history_i, u_lphr_i, u_ras_ptr_i, u_miss_i,
        output u_ready_o,
        output c_redirect_o, c_true_target_o, c_tid_o, c_need_update_o, c_miss_o,
        output c_pc_o, c_btb_target_o, c_type_o, c_cond_o, c_taken_o,
        output c_history_o, c_lphr_o, c_ras_ptr_o, busy_o
    );
endinterface

// File: rtl/wired_bpu_upd_sched.sv
// Arbitrates redirects and buffered training updates onto the predictor correction port.
// Optional tail-entry coalescing of same-PC updates: define WIRED_BPU_UPD_COALESCE_EN.
module wired_bpu_upd_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    wired_bpu_upd_sched_if.slave bus
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(FIFO_DEPTH);
    localparam bit               HOLD_EN   = (HOLD_CYCLES > 0);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  typ;
        logic        cond;
        logic        taken;
        logic [4:0]  history;
        logic [1:0]  lphr;
        logic [2:0]  ras_ptr;
        logic        miss;
    } upd_t;

    typedef enum logic {RUN, HOLD} state_t;

    upd_t             mem [FIFO_DEPTH];
    upd_t             head;
    upd_t             in_entry;
    upd_t             wr_entry;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
    logic [IDX_W-1:0] wr_idx, rd_idx, wr_addr;
    logic             empty, push, pop, alloc, coalesce, tail_miss;
    logic             ready_q, busy_q;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    assign wr_idx   = wr_ptr[IDX_W-1:0];
    assign rd_idx   = rd_ptr[IDX_W-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign head     = mem[rd_idx];
    assign push     = bus.u_valid_i & ready_q;
    assign pop      = (state == RUN) & ~bus.r_valid_i & ~empty;

    assign in_entry = '{pc: bus.u_pc_i, target: bus.u_target_i, typ: bus.u_type_i,
                        cond: bus.u_cond_i, taken: bus.u_taken_i, history: bus.u_history_i,
                        lphr: bus.u_lphr_i, ras_ptr: bus.u_ras_ptr_i, miss: bus.u_miss_i};

`ifdef WIRED_BPU_UPD_COALESCE_EN
    logic [IDX_W-1:0] tail_idx;
    upd_t             tail;
    assign tail_idx  = wr_idx - IDX_W'(1);
    assign tail      = mem[tail_idx];
    // A lone entry leaving this cycle cannot absorb the newcomer; it is allocated fresh instead.
    assign coalesce  = push & ~empty & (tail.pc[31:2] == bus.u_pc_i[31:2])
                     & ~(pop & (wr_ptr - rd_ptr == PTR_W'(1)));
    assign wr_addr   = coalesce ? tail_idx : wr_idx;
    assign tail_miss = tail.miss;
`else
    assign coalesce  = 1'b0;
    assign wr_addr   = wr_idx;
    assign tail_miss = 1'b0;
`endif

    assign alloc    = push & ~coalesce;
    assign wr_ptr_n = wr_ptr + PTR_W'(alloc);
    assign rd_ptr_n = rd_ptr + PTR_W'(pop);
    assign count_n  = wr_ptr_n - rd_ptr_n;

    always_comb begin
        wr_entry      = in_entry;
        wr_entry.miss = in_entry.miss | (coalesce & tail_miss);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_addr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= RUN;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            state  <= state_n;
            cnt    <= cnt_n;
        end
    end

    // A redirect during HOLD restarts the window so the refill gets the full quiet period.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RUN: begin
                if (bus.r_valid_i && HOLD_EN) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (bus.r_valid_i) begin
                    cnt_n = HOLD_LOAD;
                end else if (cnt == CNT_W'(1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.c_redirect_o    <= 1'b0;
            bus.c_true_target_o <= '0;
            bus.c_tid_o         <= 1'b0;
            bus.c_need_update_o <= 1'b0;
            bus.c_miss_o        <= 1'b0;
            bus.c_pc_o          <= '0;
            bus.c_btb_target_o  <= '0;
            bus.c_type_o        <= '0;
            bus.c_cond_o        <= 1'b0;
            bus.c_taken_o       <= 1'b0;
            bus.c_history_o     <= '0;
            bus.c_lphr_o        <= '0;
            bus.c_ras_ptr_o     <= '0;
            ready_q             <= 1'b0;
            busy_q              <= 1'b0;
        end else begin
            bus.c_redirect_o    <= bus.r_valid_i;
            bus.c_need_update_o <= pop;
            bus.c_miss_o        <= pop & head.miss;
            if (bus.r_valid_i) begin
                bus.c_true_target_o <= bus.r_target_i;
                bus.c_tid_o         <= bus.r_tid_i;
            end
            if (pop) begin
                bus.c_pc_o         <= head.pc;
                bus.c_btb_target_o <= head.target;
                bus.c_type_o       <= head.typ;
                bus.c_cond_o       <= head.cond;
                bus.c_taken_o      <= head.taken;
                bus.c_history_o    <= head.history;
                bus.c_lphr_o       <= head.lphr;
                bus.c_ras_ptr_o    <= head.ras_ptr;
            end
            ready_q <= (count_n != DEPTH_P);
            busy_q  <= (count_n != '0) | (state_n == HOLD);
        end
    end

    assign bus.u_ready_o = ready_q;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_wired_bpu_upd_sched.sv
// Self-checking bench for wired_bpu_upd_sched: directed vector table, corner sequences, random traffic vs queue model.
module tb_wired_bpu_upd_sched;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  typ;
        logic        cond;
        logic        taken;
        logic [4:0]  history;
        logic [1:0]  lphr;
        logic [2:0]  ras;
        logic        miss;
    } upd_t;

    typedef struct {
        bit          rv;
        logic [31:0] tgt;
        bit          uv;
        logic [31:0] pc;
        bit          exp_redirect;
        bit          exp_need;
        logic [31:0] exp_pc;
        logic [31:0] exp_target;
        bit          exp_ready;
        bit          exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wired_bpu_upd_sched_if bus ();

    wired_bpu_upd_sched #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   blocked_until = -1;
    int   issued = 0;
    bit   rdy_ok = 1'b0;
    upd_t q[$];
    bit          e_redirect, e_tid, e_need, e_miss;
    logic [31:0] e_target;
    upd_t        e_u;
    vec_t        vecs[12];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic upd_t mkUpd(logic [31:0] pc, bit miss, bit taken);
        upd_t u;
        u.pc      = pc;
        u.target  = pc ^ 32'h0000_0140;
        u.typ     = pc[3:2];
        u.cond    = pc[4];
        u.taken   = taken;
        u.history = pc[6:2];
        u.lphr    = pc[5:4];
        u.ras     = pc[4:2];
        u.miss    = miss;
        return u;
    endfunction

    function automatic vec_t mkVec(bit rv, logic [31:0] tgt, bit uv, logic [31:0] pc, bit r, bit n,
                                   logic [31:0] p, logic [31:0] t, bit rdy, bit b);
        vec_t v;
        v.rv = rv; v.tgt = tgt; v.uv = uv; v.pc = pc;
        v.exp_redirect = r; v.exp_need = n; v.exp_pc = p; v.exp_target = t;
        v.exp_ready = rdy; v.exp_busy = b;
        return v;
    endfunction

    task automatic modelReset();
        q.delete();
        e_redirect = 0; e_tid = 0; e_need = 0; e_miss = 0;
        e_target = '0; e_u = '0;
        rdy_ok = 0;
        blocked_until = cyc - 1;
    endtask

    task automatic checkOutput();
        bit ready_e;
        bit busy_e;
        ready_e = rdy_ok && (q.size() < DEPTH);
        busy_e  = (q.size() != 0) || (cyc <= blocked_until);
        chk("redirect",   32'(bus.c_redirect_o),    32'(e_redirect));
        chk("true_target", bus.c_true_target_o,     e_target);
        chk("tid",        32'(bus.c_tid_o),         32'(e_tid));
        chk("need_update", 32'(bus.c_need_update_o), 32'(e_need));
        chk("miss",       32'(bus.c_miss_o),        32'(e_miss));
        chk("pc",         bus.c_pc_o,               e_u.pc);
        chk("btb_target", bus.c_btb_target_o,       e_u.target);
        chk("type",       32'(bus.c_type_o),        32'(e_u.typ));
        chk("cond",       32'(bus.c_cond_o),        32'(e_u.cond));
        chk("taken",      32'(bus.c_taken_o),       32'(e_u.taken));
        chk("history",    32'(bus.c_history_o),     32'(e_u.history));
        chk("lphr",       32'(bus.c_lphr_o),        32'(e_u.lphr));
        chk("ras_ptr",    32'(bus.c_ras_ptr_o),     32'(e_u.ras));
        chk("u_ready",    32'(bus.u_ready_o),       32'(ready_e));
        chk("busy",       32'(bus.busy_o),          32'(busy_e));
    endtask

    // One cycle: check current outputs, drive inputs, advance the model, cross the edge.
    task automatic applyStimulus(input bit rv, input logic [31:0] tgt, input bit tid,
                                 input bit uv, input upd_t u, output bit acc);
        bit   ready_e, pop, merge;
        upd_t h;
        checkOutput();
        bus.r_valid_i   = rv;
        bus.r_target_i  = tgt;
        bus.r_tid_i     = tid;
        bus.u_valid_i   = uv;
        bus.u_pc_i      = u.pc;
        bus.u_target_i  = u.target;
        bus.u_type_i    = u.typ;
        bus.u_cond_i    = u.cond;
        bus.u_taken_i   = u.taken;
        bus.u_history_i = u.history;
        bus.u_lphr_i    = u.lphr;
        bus.u_ras_ptr_i = u.ras;
        bus.u_miss_i    = u.miss;

        ready_e = rdy_ok && (q.size() < DEPTH);
        acc     = uv && ready_e;
        pop     = !rv && (cyc > blocked_until) && (q.size() > 0);
        merge   = 1'b0;
`ifdef WIRED_BPU_UPD_COALESCE_EN
        if (acc && q.size() > 0 && !(pop && q.size() == 1))
            merge = (q[$].pc[31:2] == u.pc[31:2]);
`endif
        e_redirect = rv;
        if (rv) begin
            e_target = tgt;
            e_tid = tid;
            blocked_until = cyc + HOLD;
        end
        e_need = pop;
        e_miss = 1'b0;
        if (pop) begin
            h = q.pop_front();
            e_u = h;
            e_miss = h.miss;
        end
        if (acc) begin
            if (merge) begin
                h = u;
                h.miss = u.miss | q[$].miss;
                q[$] = h;
            end else begin
                q.push_back(u);
            end
        end
        rdy_ok = 1'b1;

        @(posedge clk);
        #1;
        cyc++;
        if (bus.c_need_update_o) issued++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, '0, a);
    endtask

    task automatic doAsyncReset();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_redirect", 32'(bus.c_redirect_o),    32'd0);
        chk("async_rst_need",     32'(bus.c_need_update_o), 32'd0);
        chk("async_rst_miss",     32'(bus.c_miss_o),        32'd0);
        chk("async_rst_pc",       bus.c_pc_o,               32'd0);
        chk("async_rst_target",   bus.c_true_target_o,      32'd0);
        chk("async_rst_ready",    32'(bus.u_ready_o),       32'd0);
        chk("async_rst_busy",     32'(bus.busy_o),          32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit   a;
        bit   found;
        int   base, idx;
        bit   first_miss, first_taken;
        upd_t u;
        logic [31:0] pa, pb, pc0, pd, pe, x;

        pa = 32'h1c00_0000; pb = 32'h1c00_0004; pc0 = 32'h1c00_0008;
        pd = 32'h1c00_0020; pe = 32'h1c00_0024; x  = 32'h1c00_0100;
        vecs[0]  = mkVec(0, 0, 0, 0,   0, 0, 0,   0, 1, 0);
        vecs[1]  = mkVec(0, 0, 1, pa,  0, 0, 0,   0, 1, 1);
        vecs[2]  = mkVec(0, 0, 1, pb,  0, 1, pa,  0, 1, 1);
        vecs[3]  = mkVec(0, 0, 1, pc0, 0, 1, pb,  0, 1, 1);
        vecs[4]  = mkVec(0, 0, 0, 0,   0, 1, pc0, 0, 1, 0);
        vecs[5]  = mkVec(0, 0, 0, 0,   0, 0, pc0, 0, 1, 0);
        vecs[6]  = mkVec(1, x, 1, pd,  1, 0, pc0, x, 1, 1);
        vecs[7]  = mkVec(0, 0, 1, pe,  0, 0, pc0, x, 1, 1);
        vecs[8]  = mkVec(0, 0, 0, 0,   0, 0, pc0, x, 1, 1);
        vecs[9]  = mkVec(0, 0, 0, 0,   0, 1, pd,  x, 1, 1);
        vecs[10] = mkVec(0, 0, 0, 0,   0, 1, pe,  x, 1, 0);
        vecs[11] = mkVec(0, 0, 0, 0,   0, 0, pe,  x, 1, 0);

        bus.r_valid_i = 0; bus.r_target_i = '0; bus.r_tid_i = 0;
        bus.u_valid_i = 0; bus.u_pc_i = '0; bus.u_target_i = '0; bus.u_type_i = '0;
        bus.u_cond_i = 0; bus.u_taken_i = 0; bus.u_history_i = '0; bus.u_lphr_i = '0;
        bus.u_ras_ptr_i = '0; bus.u_miss_i = 0;

        @(posedge clk);
        #1;
        chk("rst_need",  32'(bus.c_need_update_o), 32'd0);
        chk("rst_ready", 32'(bus.u_ready_o),       32'd0);
        chk("rst_busy",  32'(bus.busy_o),          32'd0);
        modelReset();
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].tgt, 1'b0, vecs[i].uv, mkUpd(vecs[i].pc, 0, 1), a);
            chk($sformatf("vec%0d_redirect", i), 32'(bus.c_redirect_o),    32'(vecs[i].exp_redirect));
            chk($sformatf("vec%0d_need", i),     32'(bus.c_need_update_o), 32'(vecs[i].exp_need));
            chk($sformatf("vec%0d_pc", i),       bus.c_pc_o,               vecs[i].exp_pc);
            chk($sformatf("vec%0d_target", i),   bus.c_true_target_o,      vecs[i].exp_target);
            chk($sformatf("vec%0d_ready", i),    32'(bus.u_ready_o),       32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_busy", i),     32'(bus.busy_o),          32'(vecs[i].exp_busy));
        end

        $display("[TB] redirect restart during hold");
        applyStimulus(1, 32'h1c00_0300, 1, 1, mkUpd(32'h1c00_0040, 0, 0), a);
        applyStimulus(1, 32'h1c00_0400, 0, 1, mkUpd(32'h1c00_0050, 1, 1), a);
        found = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, '0, 0, 0, '0, a);
            if (!found && bus.c_need_update_o) begin
                found = 1;
                chk("restart_latency", 32'(k), 32'd3);
            end
        end
        chk("restart_issue_seen", 32'(found), 32'd1);

        $display("[TB] back-pressure under redirect pulses");
        base = issued;
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(k < 7, 32'h1c00_0500 + 32'(k * 4), k[0], idx < 5,
                          mkUpd(32'h1c00_0200 + 32'(idx * 8), idx[0], 1), a);
            if (a) idx++;
            if (k == 3) chk("bp_ready_full", 32'(bus.u_ready_o), 32'd0);
        end
        idle(10);
        chk("bp_accepted", 32'(idx), 32'd5);
        chk("bp_issued", 32'(issued - base), 32'd5);

        $display("[TB] coalescing candidates during hold");
        base = issued;
        applyStimulus(1, 32'h1c00_0600, 0, 0, '0, a);
        applyStimulus(0, '0, 0, 1, mkUpd(32'h1c00_0010, 1, 0), a);
        applyStimulus(0, '0, 0, 1, mkUpd(32'h1c00_0010, 0, 1), a);
        found = 0; first_miss = 0; first_taken = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, '0, 0, 0, '0, a);
            if (!found && bus.c_need_update_o) begin
                found = 1;
                first_miss = bus.c_miss_o;
                first_taken = bus.c_taken_o;
            end
        end
        chk("coal_first_miss", 32'(first_miss), 32'd1);
`ifdef WIRED_BPU_UPD_COALESCE_EN
        chk("coal_issued", 32'(issued - base), 32'd1);
        chk("coal_first_taken", 32'(first_taken), 32'd1);
`else
        chk("coal_issued", 32'(issued - base), 32'd2);
        chk("coal_first_taken", 32'(first_taken), 32'd0);
`endif

        $display("[TB] async reset with queued updates in hold");
        applyStimulus(1, 32'h1c00_0700, 0, 1, mkUpd(32'h1c00_0060, 1, 1), a);
        applyStimulus(1, 32'h1c00_0704, 0, 1, mkUpd(32'h1c00_0070, 0, 1), a);
        applyStimulus(0, '0, 0, 1, mkUpd(32'h1c00_0080, 1, 0), a);
        doAsyncReset();
        base = issued;
        idle(8);
        chk("post_rst_no_stale", 32'(issued - base), 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            u = mkUpd(32'h1c00_0000 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3)),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            applyStimulus($urandom_range(0, 5) == 0, $urandom, bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 1)), u, a);
            if (i == 200) doAsyncReset();
        end
        idle(12);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
